// File: rtl/seq7_run_controller_if.sv
// Handshake/status bundle between the run controller and its surrounding logic.
//   start/periods : run request and number of full count periods to run
//   pause/abort   : level-sensitive hold and cancel requests
//   cnt/cnt_en    : current count and the step enable for a lock-step counter
//   wrap/busy/done/remaining : run status
// master = requester side, slave = controller side.
interface seq7_run_controller_if #(
  parameter int unsigned CW = 3,
  parameter int unsigned PW = 4
);
  logic          start;
  logic [PW-1:0] periods;
  logic          pause;
  logic          abort;
  logic [CW-1:0] cnt;
  logic          cnt_en;
  logic          wrap;
  logic          busy;
  logic          done;
  logic [PW-1:0] remaining;

  modport master (
    output start, periods, pause, abort,
    input  cnt, cnt_en, wrap, busy, done, remaining
  );

  modport slave (
    input  start, periods, pause, abort,
    output cnt, cnt_en, wrap, busy, done, remaining
  );
endinterface

// File: rtl/seq7_run_controller.sv
// Run controller for a modulo-MOD counting datapath. Sequences the count
// through the requested number of full 0..MOD-1 periods, with pause and
// abort, and exports a count-enable for an external lock-step counter.
//   Cp  : clock, rising edge
//   R   : asynchronous reset, active low
//   bus : seq7_run_controller_if slave modport (requests in, status out)
module seq7_run_controller #(
  parameter int unsigned MOD = 7,
  parameter int unsigned CW  = 3,
  parameter int unsigned PW  = 4
) (
  input  logic                 Cp,
  input  logic                 R,
  seq7_run_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(MOD - 1);
  localparam logic [PW-1:0] REM_ONE = PW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;
  logic          step;

  // Count advances on the next edge only from RUN with no hold or cancel.
  assign step = (state_q == RUN) & ~bus.pause & ~bus.abort;

  always_ff @(posedge Cp or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d = '0;
          if (bus.periods != '0) begin
            state_d = RUN;
            rem_d   = bus.periods;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      RUN, PAUSE: begin
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          rem_d   = '0;
          busy_d  = 1'b0;
        end else if (bus.pause) begin
          state_d = PAUSE;
        end else if (state_q == PAUSE) begin
          // Leaving PAUSE costs one edge; counting restarts on the next one.
          state_d = RUN;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
          if (rem_q == REM_ONE) begin
            state_d = DONE;
            rem_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - REM_ONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cnt       = cnt_q;
  assign bus.cnt_en    = step;
  assign bus.wrap      = wrap_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = rem_q;

endmodule
